// File: rtl/multiword_serial_adder_if.sv
// Handshake bundle for the serial wide adder.
// Operand side: in_valid/in_ready/A/B/CIN; result side: out_valid/out_ready/S/cout/ovf.
interface multiword_serial_adder_if #(
  parameter int WORDS = 4
);
  localparam int N = 16 * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         CIN;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] S;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, A, B, CIN, out_ready,
    input  in_ready, out_valid, S, cout, ovf
  );

  modport slave (
    input  in_valid, A, B, CIN, out_ready,
    output in_ready, out_valid, S, cout, ovf
  );
endinterface

// File: rtl/multiword_serial_adder.sv
// Wide adder built from one 16-bit slice, LSB slice first, one slice per clock.
// Ports: clk, rst (async, active-high), bus (slave side of the adder interface).
module multiword_serial_adder #(
  parameter int WORDS = 4,
  parameter int SLICE = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  multiword_serial_adder_if.slave bus
);

  localparam int N  = SLICE * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [N-1:0]     s_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic [IW-1:0]    idx_q;

  logic [31:0]      base;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE:0]   sum;
  logic             top_cin;
  logic             last;
  logic             accept;

  assign base   = 32'(idx_q) * 32'(SLICE);
  assign a_sl   = a_q[base +: SLICE];
  assign b_sl   = b_q[base +: SLICE];
  assign sum    = {1'b0, a_sl} + {1'b0, b_sl}
                + {{SLICE{1'b0}}, carry_q};
  // Carry into the MSB recovered from the sum bit.
  assign top_cin = a_sl[SLICE-1] ^ b_sl[SLICE-1]
                 ^ sum[SLICE-1];
  assign last   = (idx_q == IW'(WORDS - 1));
  assign accept = bus.in_valid && (state == IDLE);

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.S         = s_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = ADD;
      ADD:  if (last) state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      a_q     <= bus.A;
      b_q     <= bus.B;
      s_q     <= '0;
      carry_q <= bus.CIN;
      idx_q   <= '0;
    end else if (state == ADD) begin
      s_q[base +: SLICE] <= sum[SLICE-1:0];
      carry_q <= sum[SLICE];
      if (last) begin
        idx_q  <= '0;
        cout_q <= sum[SLICE];
        ovf_q  <= top_cin ^ sum[SLICE];
      end else begin
        idx_q  <= idx_q + 1'b1;
      end
    end
  end

endmodule
